// File: rtl/wb8_arbiter2.sv
// wb8_arbiter2: two-master round-robin arbiter for an 8-bit Wishbone slave with ack watchdog
module wb8_arbiter2 #(
  parameter int ADR_WIDTH = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                 I_wb_clk,
  input  logic                 I_reset,
  input  logic                 I_m0_stb,
  input  logic                 I_m1_stb,
  input  logic                 I_m0_we,
  input  logic                 I_m1_we,
  input  logic [ADR_WIDTH-1:0] I_m0_adr,
  input  logic [ADR_WIDTH-1:0] I_m1_adr,
  input  logic [7:0]           I_m0_dat,
  input  logic [7:0]           I_m1_dat,
  output logic                 O_m0_ack,
  output logic                 O_m1_ack,
  output logic                 O_m0_err,
  output logic                 O_m1_err,
  output logic [7:0]           O_m0_dat,
  output logic [7:0]           O_m1_dat,
  output logic                 O_s_stb,
  output logic                 O_s_we,
  output logic [ADR_WIDTH-1:0] O_s_adr,
  output logic [7:0]           O_s_dat,
  input  logic                 I_s_ack,
  input  logic [7:0]           I_s_dat
);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t state, state_n;
  logic last, last_n, gnt, gnt_n, done, stb_n, we_n;
  logic [7:0] cnt, cnt_n, dat_n, rd;
  logic [ADR_WIDTH-1:0] adr_n;
  assign rd = I_s_ack ? I_s_dat : 8'hFF;
  always_comb begin
    state_n = state;
    last_n  = last;
    gnt_n   = gnt;
    cnt_n   = cnt;
    stb_n   = O_s_stb;
    we_n    = O_s_we;
    adr_n   = O_s_adr;
    dat_n   = O_s_dat;
    done    = 1'b0;
    case (state)
      IDLE: if (I_m0_stb || I_m1_stb) begin
        gnt_n   = (I_m0_stb && I_m1_stb) ? ~last : I_m1_stb;
        last_n  = gnt_n;
        cnt_n   = '0;
        stb_n   = 1'b1;
        we_n    = gnt_n ? I_m1_we : I_m0_we;
        adr_n   = gnt_n ? I_m1_adr : I_m0_adr;
        dat_n   = gnt_n ? I_m1_dat : I_m0_dat;
        state_n = BUSY;
      end
      BUSY: if (I_s_ack || cnt == 8'(TIMEOUT - 1)) begin
        done    = 1'b1;
        stb_n   = 1'b0;
        state_n = GAP;
      end else cnt_n = cnt + 8'd1;
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      gnt      <= 1'b0;
      cnt      <= '0;
      O_s_stb  <= 1'b0;
      O_s_we   <= 1'b0;
      O_s_adr  <= '0;
      O_s_dat  <= '0;
      O_m0_ack <= 1'b0;
      O_m1_ack <= 1'b0;
      O_m0_err <= 1'b0;
      O_m1_err <= 1'b0;
      O_m0_dat <= '0;
      O_m1_dat <= '0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      gnt      <= gnt_n;
      cnt      <= cnt_n;
      O_s_stb  <= stb_n;
      O_s_we   <= we_n;
      O_s_adr  <= adr_n;
      O_s_dat  <= dat_n;
      O_m0_ack <= done && !gnt && I_s_ack;
      O_m1_ack <= done && gnt && I_s_ack;
      O_m0_err <= done && !gnt && !I_s_ack;
      O_m1_err <= done && gnt && !I_s_ack;
      if (done && !gnt) O_m0_dat <= rd;
      if (done && gnt) O_m1_dat <= rd;
    end
  end
endmodule

// File: tb/tb_wb8_arbiter2.sv
// tb_wb8_arbiter2: directed bench for wb8_arbiter2 with an LED-register slave model
module tb_wb8_arbiter2;
  logic I_wb_clk = 1'b0, I_reset = 1'b1;
  logic I_m0_stb = 0, I_m1_stb = 0, I_m0_we = 0, I_m1_we = 0;
  logic [3:0] I_m0_adr = 0, I_m1_adr = 0;
  logic [7:0] I_m0_dat = 0, I_m1_dat = 0;
  logic O_m0_ack, O_m1_ack, O_m0_err, O_m1_err, O_s_stb, O_s_we, I_s_ack;
  logic [7:0] O_m0_dat, O_m1_dat, O_s_dat, I_s_dat;
  logic [3:0] O_s_adr;
  int checks = 0, failures = 0, mode = 0;
  logic auto_drop = 1'b1;
  logic [7:0] led = 8'h00;
  logic ack_q = 1'b0;
  logic [3:0] scnt = 4'd0;

  wb8_arbiter2 #(.ADR_WIDTH(4), .TIMEOUT(4)) dut (
    .I_wb_clk(I_wb_clk), .I_reset(I_reset),
    .I_m0_stb(I_m0_stb), .I_m1_stb(I_m1_stb), .I_m0_we(I_m0_we), .I_m1_we(I_m1_we),
    .I_m0_adr(I_m0_adr), .I_m1_adr(I_m1_adr), .I_m0_dat(I_m0_dat), .I_m1_dat(I_m1_dat),
    .O_m0_ack(O_m0_ack), .O_m1_ack(O_m1_ack), .O_m0_err(O_m0_err), .O_m1_err(O_m1_err),
    .O_m0_dat(O_m0_dat), .O_m1_dat(O_m1_dat), .O_s_stb(O_s_stb), .O_s_we(O_s_we),
    .O_s_adr(O_s_adr), .O_s_dat(O_s_dat), .I_s_ack(I_s_ack), .I_s_dat(I_s_dat)
  );

  always #5 I_wb_clk = ~I_wb_clk;

  // slave modes: 0 = registered ack of strobe, 1 = never acks, 2 = acks in 4th strobe cycle
  always @(posedge I_wb_clk) begin
    ack_q <= O_s_stb;
    scnt  <= O_s_stb ? scnt + 4'd1 : 4'd0;
    if (O_s_stb && O_s_we) led <= O_s_dat;
  end
  assign I_s_ack = (mode == 0) ? ack_q : (mode == 2) ? (O_s_stb && scnt == 4'd3) : 1'b0;
  assign I_s_dat = led;

  function automatic logic [63:0] outs();
    return 64'({O_s_stb, O_s_we, O_s_adr, O_s_dat, O_m0_ack, O_m1_ack, O_m0_err, O_m1_err, O_m0_dat, O_m1_dat});
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_wb_clk);
    #1;
    if (auto_drop && (O_m0_ack || O_m0_err)) I_m0_stb = 1'b0;
    if (auto_drop && (O_m1_ack || O_m1_err)) I_m1_stb = 1'b0;
  endtask

  task automatic do_reset();
    I_reset = 1'b1;
    tick();
    tick();
    check("rst_out", outs(), 64'd0);
    I_reset = 1'b0;
  endtask

  initial begin
    int n0, n1, n, a0, a1, sc, e;
    logic prev;
    do_reset();
    // single m0 write
    I_m0_we = 1; I_m0_adr = 4'h3; I_m0_dat = 8'hA5; I_m0_stb = 1;
    tick();
    check("t1_stb", 64'(O_s_stb), 64'd1);
    check("t1_bus", 64'({O_s_we, O_s_adr, O_s_dat}), 64'({1'b1, 4'h3, 8'hA5}));
    tick();
    check("t1_ack_c2", 64'({O_m0_ack, O_m1_ack}), 64'd0);
    tick();
    check("t1_ack_c3", 64'({O_m0_ack, O_m1_ack}), 64'b10);
    tick();
    check("t1_ack_c4", 64'(O_m0_ack), 64'd0);
    check("t1_led", 64'(led), 64'hA5);
    // simultaneous writes after reset
    do_reset();
    I_m0_adr = 4'h1; I_m0_dat = 8'h11; I_m0_we = 1;
    I_m1_adr = 4'h2; I_m1_dat = 8'h22; I_m1_we = 1;
    I_m0_stb = 1; I_m1_stb = 1;
    n0 = 0; n1 = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n0 += int'(O_m0_ack);
      n1 += int'(O_m1_ack);
      if (c == 1) check("t2_first", 64'(O_s_dat), 64'h11);
      if (c == 5) check("t2_second", 64'(O_s_dat), 64'h22);
    end
    check("t2_n0", 64'(n0), 64'd1);
    check("t2_n1", 64'(n1), 64'd1);
    check("t2_led", 64'(led), 64'h22);
    // continuous contention reads
    auto_drop = 0;
    I_m0_we = 0; I_m1_we = 0; I_m0_stb = 1; I_m1_stb = 1;
    n = 0; a0 = 0; a1 = 0; prev = 0;
    for (int c = 1; c <= 31; c++) begin
      tick();
      if (O_s_stb && !prev) begin
        if (n < 8) begin
          check("rr_who", 64'(O_s_adr), (n % 2 == 1) ? 64'd2 : 64'd1);
          check("rr_cyc", 64'(c), 64'(1 + 4 * n));
        end
        n++;
      end
      if (O_m0_ack) check("rr_d0", 64'(O_m0_dat), 64'h22);
      if (O_m1_ack) check("rr_d1", 64'(O_m1_dat), 64'h22);
      a0 += int'(O_m0_ack);
      a1 += int'(O_m1_ack);
      prev = O_s_stb;
    end
    check("rr_n", 64'(n), 64'd8);
    check("rr_a0", 64'(a0), 64'd4);
    check("rr_a1", 64'(a1), 64'd4);
    I_m0_stb = 0; I_m1_stb = 0; auto_drop = 1;
    tick();
    tick();
    // watchdog timeout on m1 read
    mode = 1; I_m1_adr = 4'h5; I_m1_stb = 1;
    sc = 0; e = 0; a1 = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      sc += int'(O_s_stb);
      a1 += int'(O_m1_ack);
      if (O_m1_err) begin
        e++;
        check("t4_errdat", 64'(O_m1_dat), 64'hFF);
        check("t4_errcyc", 64'(c), 64'd5);
      end
    end
    check("t4_stb", 64'(sc), 64'd4);
    check("t4_err", 64'(e), 64'd1);
    check("t4_ack", 64'(a1), 64'd0);
    mode = 0; I_m0_adr = 4'h6; I_m0_stb = 1;
    tick();
    tick();
    tick();
    check("t4_next", 64'({O_m0_ack, O_m0_err, O_m0_dat}), 64'({2'b10, 8'h22}));
    tick();
    // ack coincides with the timeout edge
    mode = 2; I_m0_adr = 4'h7; I_m0_stb = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 4) check("t5_pre", 64'({O_m0_ack, O_m0_err}), 64'd0);
      if (c == 5) check("t5_race", 64'({O_m0_ack, O_m0_err, O_m0_dat}), 64'({2'b10, 8'h22}));
    end
    tick();
    // reset during BUSY, then fresh traffic
    mode = 1; I_m1_adr = 4'h9; I_m1_stb = 1;
    tick();
    tick();
    I_reset = 1;
    tick();
    check("t6_rst", outs(), 64'd0);
    I_reset = 0; mode = 0;
    I_m0_we = 1; I_m0_adr = 4'h8; I_m0_dat = 8'h3C; I_m0_stb = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) check("t6_grant", 64'({O_s_stb, O_s_we, O_s_adr, O_s_dat}), 64'({2'b11, 4'h8, 8'h3C}));
      if (c == 3) check("t6_ack", 64'({O_m0_ack, O_m1_ack, O_m1_err}), 64'b100);
      if (c == 4) check("t6_led", 64'(led), 64'h3C);
      if (c == 7) check("t6_m1", 64'({O_m1_ack, O_m1_err, O_m1_dat}), 64'({2'b10, 8'h3C}));
    end
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb8_arbiter2.md
# wb8_arbiter2

Two-master round-robin arbiter for the 8-bit Wishbone peripheral bus. It lets the CPU data port (master 0) and a secondary master (master 1, e.g. a debug or DMA engine) share one 8-bit slave such as the LED register. Each transaction is held until the slave acks, followed by a one-cycle bus-idle gap. A watchdog aborts transfers the slave never acks.

## Interface
- ADR_WIDTH, 4: width of the address forwarded to the slave.
- TIMEOUT, 15: maximum BUSY cycles without slave ack before abort; legal range 2..255.

- I_wb_clk  in  1  clock; all logic on the rising edge.
- I_reset  in  1  reset: synchronous, active-high.
- I_m0_stb, I_m1_stb  in  1  master request strobes; held until that master's ack or err.
- I_m0_we, I_m1_we  in  1  write enable.
- I_m0_adr, I_m1_adr  in  ADR_WIDTH  address.
- I_m0_dat, I_m1_dat  in  8  write data.
- O_m0_ack, O_m1_ack  out  1  one-cycle completion pulse.
- O_m0_err, O_m1_err  out  1  one-cycle timeout pulse.
- O_m0_dat, O_m1_dat  out  8  read data; valid while ack or err is high.
- O_s_stb, O_s_we  out  1  slave strobe and write enable.
- O_s_adr  out  ADR_WIDTH  slave address.
- O_s_dat  out  8  slave write data.
- I_s_ack  in  1  slave ack.
- I_s_dat  in  8  slave read data.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset sets state to IDLE, the last-grant pointer to 1, and the watchdog counter to 0.
- State IDLE:
  - No strobe: remain in IDLE.
  - One strobe: grant that master.
  - Both strobes: grant the master that is not the last-grant pointer.
  - On grant: latch the winner's adr, dat and we into O_s_*; set O_s_stb=1; clear the counter; update the pointer; go to BUSY.
- State BUSY: O_s_* stay stable.
  - I_s_ack=1: O_s_stb<=0; O_mG_dat<=I_s_dat; O_mG_ack<=1; go to GAP.
  - Else, if counter==TIMEOUT-1: O_s_stb<=0; O_mG_dat<=8'hFF; O_mG_err<=1; go to GAP.
  - Else: counter increments.
  - Ack and timeout on the same edge: ack wins.
- State GAP: exactly one cycle.
  - Clear ack and err.
  - I_s_ack is ignored. This absorbs the trailing ack from slaves that ack every cycle strobe is high.
  - Go to IDLE.
- Ungranted master: its ack and err stay 0; its request waits.
- O_mN_dat holds its last value outside ack/err cycles.
- Master obligation: deassert or change the strobe on the edge where ack or err is sampled high. The arbiter samples requests only in IDLE, so a strobe still high at the GAP edge is never treated as a new request.
- Strobe withdrawn during BUSY: the transaction still completes on the slave; the ack pulse is still issued.
- O_s_we=0 during BUSY is a read; I_s_dat is returned.

## Timing
- Latency from request to grant: a strobe high in cycle 0 gives O_s_stb=1 in cycle 1.
- Single-cycle-ack slave (slave registers ack from strobe): I_s_ack high in cycle 2, master ack in cycle 3, GAP in cycle 3, IDLE in cycle 4, next grant at the earliest in cycle 5.
- Throughput: one transfer per 4 cycles under continuous contention.
- Timeout: O_s_stb is high for exactly TIMEOUT cycles; err is asserted in the following cycle.
- Reset mid-BUSY: on the next cycle O_s_stb=0 and all acks and errs are 0. The aborted master gets neither ack nor err.
- Fairness: under continuous requests from both masters, grants strictly alternate. The first grant after reset goes to m0.

## Test plan
- m0 writes 0xA5 to the LED slave, m1 idle -> O_s_stb high in cycle 1; O_m0_ack high only in cycle 3; LED output becomes 0xA5; O_m1_ack stays 0.
- Both masters strobe in the same cycle after reset (m0 writes 0x11, m1 writes 0x22) -> m0 is served first, then m1; final LED value is 0x22; each ack is a single pulse.
- Both masters issue continuous back-to-back reads for 8 transactions -> grants alternate m0,m1,...; returned data equals the LED value; a new grant occurs every 4 cycles.
- Stub slave that never acks, TIMEOUT=4, m1 read -> O_s_stb is high for exactly 4 cycles; O_m1_err pulses once with O_m1_dat=0xFF; O_m1_ack stays 0; the next request is granted normally.
- Slave acks on the same edge the timeout would fire -> O_mG_ack=1, O_mG_err=0, data comes from I_s_dat.
- I_reset asserted during BUSY, then a new m0 write of 0x3C -> all outputs are 0 after reset; the new write completes normally; m0 is granted first.
